// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Holds the default operand width and the FSM state encodings.
package serial_subtractor_pkg;
    localparam int DATA_WIDTH_DEF = 32;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;
endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell built from gate primitives.
// D = A ^ B ^ BI, BO = (~A & B) | (~(A ^ B) & BI).
module full_subtractor (
    output logic D,
    output logic BO,
    input  logic A,
    input  logic B,
    input  logic BI
);
    logic axb;
    logic na;
    logic naxb;
    logic t0;
    logic t1;

    xor g_x0 (axb, A, B);
    xor g_x1 (D, axb, BI);
    not g_n0 (na, A);
    not g_n1 (naxb, axb);
    and g_a0 (t0, na, B);
    and g_a1 (t1, naxb, BI);
    or  g_o0 (BO, t0, t1);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, one bit per clock.
// Reuses a single full_subtractor cell with a registered borrow.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic [DATA_WIDTH-1:0] DIFF,
    output logic                  BORROW,
    output logic                  OVERFLOW,
    output logic                  ZERO,
    output logic                  BUSY,
    output logic                  DONE
);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] opa_q, opa_d;
    logic [DATA_WIDTH-1:0] opb_q, opb_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  brw_q, brw_d;
    logic                  sa_q, sa_d;
    logic                  sb_q, sb_d;
    logic [DATA_WIDTH-1:0] diff_q, diff_d;
    logic                  borrow_q, borrow_d;
    logic                  ovf_q, ovf_d;
    logic                  zero_q, zero_d;

    logic                  cell_d;
    logic                  cell_bo;
    logic [DATA_WIDTH-1:0] res_shift;

    full_subtractor u_cell (
        .D  (cell_d),
        .BO (cell_bo),
        .A  (opa_q[0]),
        .B  (opb_q[0]),
        .BI (brw_q)
    );

    assign res_shift = {cell_d, res_q[DATA_WIDTH-1:1]};

    // Next-state: accept, shift one bit, and publish the result on the last bit
    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        brw_d    = brw_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (START) begin
                    state_d = ST_SHIFT;
                    opa_d   = A;
                    opb_d   = B;
                    sa_d    = A[DATA_WIDTH-1];
                    sb_d    = B[DATA_WIDTH-1];
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                opa_d = {1'b0, opa_q[DATA_WIDTH-1:1]};
                opb_d = {1'b0, opb_q[DATA_WIDTH-1:1]};
                res_d = res_shift;
                brw_d = cell_bo;
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (cnt_q == LAST) begin
                    state_d  = ST_DONE;
                    diff_d   = res_shift;
                    borrow_d = cell_bo;
                    ovf_d    = (sa_q != sb_q) && (cell_d != sa_q);
                    zero_d   = (res_shift == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            brw_q    <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            brw_q    <= brw_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign DIFF     = diff_q;
    assign BORROW   = borrow_q;
    assign OVERFLOW = ovf_q;
    assign ZERO     = zero_q;
    assign BUSY     = (state_q == ST_SHIFT);
    assign DONE     = (state_q == ST_DONE);
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor.
// Table-driven vectors plus back-to-back, ignored-START and reset sequences.
module tb_serial_subtractor;
    localparam int W = 32;

    logic         CLK;
    logic         RST;
    logic         START;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] DIFF;
    logic         BORROW;
    logic         OVERFLOW;
    logic         ZERO;
    logic         BUSY;
    logic         DONE;

    int n_chk;
    int n_fail;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
        logic         zero;
    } vec_t;

    vec_t vecs[6];

    serial_subtractor #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .A        (A),
        .B        (B),
        .DIFF     (DIFF),
        .BORROW   (BORROW),
        .OVERFLOW (OVERFLOW),
        .ZERO     (ZERO),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge CLK);
        A = a;
        B = b;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_done(output int busy_cnt);
        bit ok;
        ok = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (DONE) begin
                ok = 1'b1;
                break;
            end
            if (BUSY) busy_cnt++;
            @(negedge CLK);
        end
        chk("done_timeout", 32'(ok), 32'd1);
    endtask

    task automatic chk_result(input string tag, input vec_t v);
        chk({tag, "_diff"}, DIFF, v.diff);
        chk({tag, "_borrow"}, 32'(BORROW), 32'(v.borrow));
        chk({tag, "_ovf"}, 32'(OVERFLOW), 32'(v.ovf));
        chk({tag, "_zero"}, 32'(ZERO), 32'(v.zero));
    endtask

    initial begin
        int bc;
        vec_t v;
        n_chk = 0;
        n_fail = 0;
        START = 1'b0;
        A = '0;
        B = '0;

        vecs[0] = '{32'd5, 32'd3, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF,
                    1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                    1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'h1234_5678, 32'h0000_0078, 32'h1234_5600,
                    1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000,
                    1'b1, 1'b1, 1'b0};

        RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_diff", DIFF, 32'd0);
        chk("rst_flags", {28'd0, BORROW, OVERFLOW, ZERO, BUSY}, 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        RST = 1'b1;

        for (int i = 0; i < 6; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_done(bc);
            chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'd32);
            chk_result($sformatf("v%0d", i), vecs[i]);
            @(negedge CLK);
            chk($sformatf("v%0d_done_pulse", i), {30'd0, DONE, BUSY}, 32'd0);
        end

        // Equal operands, START held high through DONE
        @(negedge CLK);
        A = 32'hDEAD_BEEF;
        B = 32'hDEAD_BEEF;
        START = 1'b1;
        @(negedge CLK);
        wait_done(bc);
        chk("eq_busy_cycles", 32'(bc), 32'd32);
        v = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 1'b1};
        chk_result("eq", v);
        A = 32'd7;
        B = 32'd2;
        @(negedge CLK);
        START = 1'b0;
        chk("b2b_no_idle", {30'd0, BUSY, DONE}, 32'd2);
        chk("b2b_hold_zero", 32'(ZERO), 32'd1);
        wait_done(bc);
        chk("b2b_busy_cycles", 32'(bc), 32'd32);
        v = '{32'd7, 32'd2, 32'd5, 1'b0, 1'b0, 1'b0};
        chk_result("b2b", v);

        // START during SHIFT is ignored; inputs may change after capture
        start_op(32'd10, 32'd4);
        repeat (9) @(negedge CLK);
        chk("hold_diff", DIFF, 32'd5);
        A = 32'd1;
        B = 32'd1;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_done(bc);
        chk("ign_busy_cycles", 32'(bc + 10), 32'd32);
        v = '{32'd10, 32'd4, 32'd6, 1'b0, 1'b0, 1'b0};
        chk_result("ign", v);
        @(negedge CLK);
        chk("ign_idle", {30'd0, BUSY, DONE}, 32'd0);

        // Reset mid-operation discards everything immediately
        start_op(32'h8000_0000, 32'd1);
        repeat (14) @(negedge CLK);
        chk("pre_rst_busy", 32'(BUSY), 32'd1);
        #2 RST = 1'b0;
        #1;
        chk("mid_rst_diff", DIFF, 32'd0);
        chk("mid_rst_flags", {27'd0, BORROW, OVERFLOW, ZERO, BUSY, DONE},
            32'd0);
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (DONE || BUSY) bc++;
        end
        chk("rst_no_done", 32'(bc), 32'd0);
        RST = 1'b1;
        start_op(32'd0, 32'd1);
        wait_done(bc);
        chk("post_rst_busy_cycles", 32'(bc), 32'd32);
        v = '{32'd0, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        chk_result("post_rst", v);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle, bit-serial two's-complement subtractor: DIFF = A - B, one bit per clock.
- A single 1-bit full-subtractor cell is reused each cycle, with a registered borrow.
- Low-area alternative to the ripple adder/subtractor path in the ALU; intended for the multi-cycle execution unit.
- Start/done handshake; also produces unsigned-borrow, signed-overflow and zero flags.

Parameters:
- DATA_WIDTH, 32, operand/result width in bits (>= 2); default comes from the shared project definitions.
- CNT_WIDTH, 6, bit-counter width; must satisfy 2**CNT_WIDTH > DATA_WIDTH.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only in IDLE or DONE.
- A  input  DATA_WIDTH  minuend; captured on accepted START.
- B  input  DATA_WIDTH  subtrahend; captured on accepted START.
- DIFF  output  DATA_WIDTH  result A - B mod 2**DATA_WIDTH.
- BORROW  output  1  1 when unsigned A < B.
- OVERFLOW  output  1  signed overflow of A - B.
- ZERO  output  1  DIFF == 0.
- BUSY  output  1  high while bits are being processed.
- DONE  output  1  one-cycle pulse when the result becomes valid.

Behaviour:
- Reset (RST low, asynchronous): state = IDLE; DIFF = 0, BORROW = 0, OVERFLOW = 0, ZERO = 0, BUSY = 0, DONE = 0; internal operand/result shift registers, counter and borrow register cleared. Reset takes effect immediately, including mid-operation; the partial result is discarded and no DONE is issued.
- States: IDLE, SHIFT, DONE.
  - IDLE/DONE to SHIFT: on a rising edge with START = 1.
    - Latch A and B into shift registers; save sign bits A[MSB] and B[MSB].
    - Borrow register = 0, counter = 0, BUSY = 1.
  - SHIFT: each edge, cell inputs are a = opA[0], b = opB[0], bi = borrow register.
    - Cell computes d = a^b^bi and bo = (~a&b) | (~(a^b)&bi).
    - d is shifted into the result MSB (result shifts right); opA and opB shift right.
    - Borrow register = bo; counter increments.
  - SHIFT to DONE: on the edge that processes the bit with counter == DATA_WIDTH-1.
    - The result register is then complete and copied to DIFF.
    - BORROW = final bo.
    - OVERFLOW = (signA != signB) && (DIFF[MSB] != signA).
    - ZERO = (result == 0).
    - BUSY = 0, DONE = 1.
  - DONE to IDLE: next edge if START = 0; DONE drops to 0.
  - DONE to SHIFT: next edge if START = 1 (back-to-back operation); DONE drops to 0.
- Latency: START accepted at edge k; DONE is high in the cycle after edge k+DATA_WIDTH, i.e. exactly DATA_WIDTH cycles of BUSY followed by one DONE cycle.
- START while in SHIFT is ignored; A and B may change freely after acceptance.
- DIFF and flags hold their last completed value until the next completion; they are not cleared by a new START.
- A == B gives DIFF = 0, ZERO = 1, BORROW = 0, OVERFLOW = 0.
- Counter never wraps: it is reset on every accepted START.

Decomposition:
- DATA_WIDTH default and the state encodings (IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10) are defined in the shared project definitions include file.
- One sub-module is natural: full_subtractor (1-bit; ports D, BO, A, B, BI), purely combinational, built from gate primitives in the same style as the existing adder cells.
- FSM, counter, shift registers and flag logic live in serial_subtractor.

Test Plan:
- Reset then A = 5, B = 3, START one cycle -> BUSY high 32 cycles, then DONE one cycle; DIFF = 0x00000002, BORROW = 0, OVERFLOW = 0, ZERO = 0.
- A = 3, B = 5 -> DIFF = 0xFFFFFFFE, BORROW = 1, OVERFLOW = 0, ZERO = 0.
- Signed overflow:
  - A = 0x80000000, B = 0x00000001 -> DIFF = 0x7FFFFFFF, OVERFLOW = 1, BORROW = 0.
  - A = 0x7FFFFFFF, B = 0xFFFFFFFF -> DIFF = 0x80000000, OVERFLOW = 1, BORROW = 1.
- A = B = 0xDEADBEEF -> DIFF = 0, ZERO = 1, BORROW = 0; then START held high through DONE -> second operation starts with no IDLE cycle and DONE pulses again 32 cycles later.
- Start A = 10, B = 4; pulse START with A = 1, B = 1 at cycle 10 of SHIFT -> ignored; DIFF = 6 at DONE, completed on schedule.
- Start operation, drive RST low at cycle 15 -> all outputs 0 immediately, no DONE; after release, a new START with A = 0, B = 1 gives DIFF = 0xFFFFFFFF, BORROW = 1.
